rv32m_seq_multiplier: RTL and testbench

- Multi-cycle radix-2 shift-and-add multiplier executing RV32M MUL, MULH, MULHSU and MULHU.
- Sits downstream of the operand-read/decode stage and alongside the ALU adder chain in the EX stage.
- Result is returned to writeback through a valid/ready handshake.
- One operation in flight at a time; the pipeline stalls on in_ready/out_valid.

---
 rtl/rv32m_seq_multiplier_if.sv | 19 +
 rtl/rv32m_seq_multiplier.sv | 99 +++++++++
 tb/tb_rv32m_seq_multiplier.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rv32m_seq_multiplier_if.sv
// Issue/writeback handshake bundle for the sequential RV32M multiplier.
// The master side is the pipeline (EX issue plus writeback); the slave side is the multiplier.
interface rv32m_seq_multiplier_if #(parameter int XLEN = 32);
  logic            kill;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (output kill, in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, result, busy);
  modport slave  (input  kill, in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, result, busy);
endinterface

// File: rtl/rv32m_seq_multiplier.sv
// Radix-2 shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are converted to magnitudes on accept; the product sign is restored on the last step.
module rv32m_seq_multiplier #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic                  clk,
  input logic                  rst,
  rv32m_seq_multiplier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] sum, prod;

  always_comb begin
    // op 01 (MULH) treats both signed, 10 (MULHSU) only rs1 signed
    a_neg = (bus.op == 2'b01 || bus.op == 2'b10) && bus.a[XLEN-1];
    b_neg = (bus.op == 2'b01) && bus.b[XLEN-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
    sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod  = neg_q ? -sum : sum;

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;

    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d  = BUSY;
        op_d     = bus.op;
        neg_d    = a_neg ^ b_neg;
        mcand_d  = {{XLEN{1'b0}}, a_mag};
        mplier_d = b_mag;
        acc_d    = '0;
        cnt_d    = '0;
      end
      BUSY: begin
        // multiplicand walks left, multiplier walks right: no barrel shifter
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d  = DONE;
          result_d = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // flush beats both accept and the writeback handshake
    if (bus.kill) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
endmodule

// File: tb/tb_rv32m_seq_multiplier.sv
// Self-checking bench: directed vector table, kill/reset sequences, and random ops
// compared against a signed 64-bit arithmetic reference.
module tb_rv32m_seq_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rv32m_seq_multiplier_if #(.XLEN(32)) bus();
  rv32m_seq_multiplier #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    sa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    sb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Issue one op, check latency, optionally stall writeback, then complete the handshake.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int hold, output logic [31:0] res);
    int lat;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (lat < 32) chk("busy_mid", 32'(bus.busy), 32'd1);
    end
    chk("latency", 32'(lat), 32'd32);
    res = bus.result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_result", bus.result, res);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("idle_after_hs", 32'(bus.in_ready), 32'd1);
    chk("busy_after_hs", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] r, x, y;
    logic [1:0]  o;
    int          seen;

    bus.kill = 1'b0; bus.in_valid = 1'b0; bus.op = 2'b00;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;

    vecs.push_back('{"mul_7x6",          2'b00, 32'd7,        32'd6,        0, 32'h0000002A});
    vecs.push_back('{"mul_min_m1",       2'b00, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000});
    vecs.push_back('{"mulh_min_m1",      2'b01, 32'h80000000, 32'hFFFFFFFF, 0, 32'h00000000});
    vecs.push_back('{"mulhu_min_m1",     2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 32'h7FFFFFFF});
    vecs.push_back('{"mulhu_m1_m1",      2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE});
    vecs.push_back('{"mul_m1_m1",        2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000001});
    vecs.push_back('{"mulhsu_m1_m1",     2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFF});
    vecs.push_back('{"mulh_neg_x0",      2'b01, 32'hFFFFFFFB, 32'd0,        0, 32'h00000000});
    vecs.push_back('{"mulhsu_backpress", 2'b10, 32'hFFFFFFFB, 32'd3,        5, 32'hFFFFFFFF});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, r);
      chk(vecs[i].name, r, vecs[i].exp);
    end

    // kill in BUSY cycle 10: the aborted result must never surface
    bus.op = 2'b00; bus.a = 32'd123; bus.b = 32'd456; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; bus.kill = 1'b1;
    @(posedge clk); #1; bus.kill = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("kill_no_valid", 32'(seen), 32'd0);
    chk("kill_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(2'b01, 32'hFFFFFFFB, 32'd3, 0, r);
    chk("post_kill_mulh", r, 32'hFFFFFFFF);
    do_op(2'b00, 32'hFFFFFFFB, 32'd3, 0, r);
    chk("post_kill_mul", r, 32'hFFFFFFF1);

    // reset pulsed mid-BUSY
    bus.op = 2'b11; bus.a = 32'hDEADBEEF; bus.b = 32'h12345678; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    #1; chk("in_ready_during_rst", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(2'b01, 32'hFFFFFFFB, 32'd3, 0, r);
    chk("post_rst_mulh", r, 32'hFFFFFFFF);

    // kill together with in_valid in IDLE: no accept
    bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9; bus.in_valid = 1'b1; bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.kill = 1'b0;
    chk("kill_accept_busy", 32'(bus.busy), 32'd0);
    chk("kill_accept_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      if (i % 5 == 0) x = 32'h80000000;
      if (i % 7 == 0) y = 32'h0;
      do_op(o, x, y, i % 3, r);
      chk("random", r, ref_mul(o, x, y));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
